alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Generalised to WIDTH bits; adds SUB, SHL, SHR and an iterative shift-add MUL.
- Returns registered result and flags: carry, zero, negative, overflow.
- Sits between the cpu_controller decode stage and the writeback register, using valid/ready on both sides.

Parameters:
WIDTH, 8, operand/result width in bits (>=2; power of two for the shift-amount field).
MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL op returns zero in one cycle.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept a request.
op  input  3  opcode (see Decomposition).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; low $clog2(WIDTH) bits give the shift amount for shift ops.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  registered result.
carry  output  1  carry / borrow / shifted-out bit / MUL high-half nonzero.
zero  output  1  result == 0.
neg  output  1  result[WIDTH-1].
ovf  output  1  signed overflow; ADD and SUB only, else 0.
busy  output  1  high in MUL or DONE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, result=0, all flags=0, out_valid=0. in_ready=0 while rst is high.
- Reset mid-operation aborts it. No out_valid is produced for the aborted request.
- States:
  - IDLE: in_ready=1. Accept = in_valid&&in_ready at an edge.
  - MUL: iterative multiply in progress.
  - DONE: out_valid=1.
- Simple ops (AND, OR, XOR, ADD, SUB, SHL, SHR, and MUL when MUL_EN=0):
  - Computed from the inputs at the accept edge; result and flags registered at that edge.
  - Next state is DONE, so out_valid is high in the cycle after acceptance (latency 1).
- MUL with MUL_EN=1:
  - At the accept edge, latch a and b; clear a 2*WIDTH accumulator; counter=0; go to MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand; then multiplicand<<=1, multiplier>>=1, counter++.
  - After exactly WIDTH MUL cycles, register the result, go to DONE.
  - out_valid is first high WIDTH+1 cycles after the acceptance cycle.
- In DONE, hold result and flags stable until out_valid&&out_ready, then go to IDLE.
- in_ready=0 in MUL and DONE. in_valid there is ignored, not queued. Max throughput is 1 op per 2 cycles.
- Arithmetic is unsigned for carry and two's-complement for ovf:
  - ADD: {carry,result}=a+b; ovf=(a[MSB]==b[MSB])&&(result[MSB]!=a[MSB]).
  - SUB: result=a-b mod 2^WIDTH; carry=1 iff a<b (borrow); ovf=(a[MSB]!=b[MSB])&&(result[MSB]!=a[MSB]).
  - AND/OR/XOR: carry=0.
  - SHL: logical left by amount s. carry = last bit shifted out, i.e. a[WIDTH-s]. s=0 gives result=a, carry=0.
  - SHR: logical right by s. carry = a[s-1]. s=0 gives result=a, carry=0.
  - MUL: result = product[WIDTH-1:0]; carry = |product[2*WIDTH-1:WIDTH].
  - MUL with MUL_EN=0: result=0, carry=0, zero=1.
- zero and neg are always derived from the registered result.

Decomposition:
- Package alu_pkg holds:
  - op codes: AND=0, OR=1, XOR=2, ADD=3, SUB=4, SHL=5, SHR=6, MUL=7;
  - state encoding: IDLE=0, MUL=1, DONE=2;
  - a function computing the simple-op result and flags.
- One sub-module, alu_mul_seq: the WIDTH-iteration shift-add multiplier.
  - Interface: start, done pulse, 2*WIDTH product.
  - Instantiated under a generate block only when MUL_EN=1.

Test Plan:
1. WIDTH=8, ADD a=0xFF b=0x01 -> result 0x00, carry=1, zero=1, ovf=0; out_valid high the cycle after accept.
2. SUB a=0x80 b=0x01 -> result 0x7F, carry=0, ovf=1, neg=0. SUB a=0x01 b=0x02 -> result 0xFF, carry=1, neg=1.
3. MUL a=0x0F b=0x11 -> result 0xFF, carry=0; out_valid first high exactly 9 cycles after accept. MUL 0x10*0x10 -> result 0x00, carry=1, zero=1.
4. ADD 0x05+0x03, hold out_ready=0 for 5 cycles while driving in_valid=1 -> result stays 0x08, in_ready=0, no new op accepted. out_ready=1 -> IDLE next cycle.
5. Start MUL, assert rst for one cycle 3 cycles in -> out_valid never rises; in_ready=1 after rst drops. Then AND 0xF0&0x3C -> 0x30.
6. SHL a=0x81 b=1 -> 0x02, carry=1. SHL b=0 -> 0x81, carry=0. SHR a=0x81 b=7 -> 0x01, carry=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and the single-cycle ALU datapath for alu_seq.
// Latency: purely combinational helper functions; no state.
// Backpressure: n/a (no handshake here).
//   op_e         : opcode encoding seen on the request bus
//   state_e      : controller state encoding
//   alu_simple() : result/carry/ovf for every op except the iterative MUL
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Package functions cannot see a module's WIDTH, so the datapath is
  // evaluated at MAX_W bits and trimmed to the live width w. WIDTH must
  // therefore not exceed MAX_W.
  localparam int unsigned MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] result;
    logic             carry;
    logic             ovf;
  } simple_res_t;

  // Variable bit select done as a shift, so no index-width mismatch.
  function automatic logic bit_at(input logic [MAX_W:0] v, input int unsigned idx);
    logic [MAX_W:0] t;
    t = v >> idx;
    return t[0];
  endfunction

  // a and b arrive zero-extended from w bits.
  function automatic simple_res_t alu_simple(input op_e op,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned w);
    simple_res_t      r;
    logic [MAX_W-1:0] mask;
    logic [MAX_W:0]   wide;
    int unsigned      s;
    logic             a_msb, b_msb, r_msb;

    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    // Shift amount is the low log2(w) bits of b (w is a power of two).
    s    = 32'(b & MAX_W'(w - 1));
    r    = '0;
    wide = '0;

    unique case (op)
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        r.result = wide[MAX_W-1:0] & mask;
        r.carry  = bit_at(wide, w);
      end
      OP_SUB: begin
        wide     = {1'b0, a} - {1'b0, b};
        r.result = wide[MAX_W-1:0] & mask;
        r.carry  = (a < b);
      end
      OP_SHL: begin
        r.result = (a << s) & mask;
        r.carry  = (s == 0) ? 1'b0 : bit_at({1'b0, a}, w - s);
      end
      OP_SHR: begin
        r.result = a >> s;
        r.carry  = (s == 0) ? 1'b0 : bit_at({1'b0, a}, s - 1);
      end
      default: ; // MUL without a multiplier: zero result, no carry
    endcase

    a_msb = bit_at({1'b0, a}, w - 1);
    b_msb = bit_at({1'b0, b}, w - 1);
    r_msb = bit_at({1'b0, r.result}, w - 1);
    if (op == OP_ADD) begin
      r.ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end else if (op == OP_SUB) begin
      r.ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus between the decode stage, alu_seq and writeback.
// Latency: wires only.
// Backpressure: valid/ready on both the request and the response side.
//   slave  : the ALU (consumes requests, produces results)
//   master : the requester/consumer side
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, zero, neg, ovf
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, zero, neg, ovf
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Latency: WIDTH cycles from start; done pulses in the last iteration cycle.
// Backpressure: none; the controller starts it only when it can take the product.
//   clk, rst : clock, synchronous active-high reset (aborts a run)
//   start    : load a/b and begin
//   done     : one-cycle pulse; product is final during that cycle
//   product  : 2*WIDTH-bit product
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d = 1'b0;
        done  = 1'b1;
      end
    end
  end

  // Expose the post-iteration sum so the controller can register the final
  // product at the same edge that retires the last iteration.
  assign product = acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and carry/zero/neg/ovf flags.
// Latency: 1 cycle for simple ops, WIDTH+1 cycles for MUL (MUL_EN=1).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if slave (in_valid/in_ready/op/a/b, out_valid/out_ready/result/flags)
//   busy     : high while multiplying or holding an unconsumed result
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus,
  output logic     busy
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               accept, mul_start, mul_done, load;
  logic [2*WIDTH-1:0] mul_prod;
  simple_res_t        simple;

  assign accept    = bus.in_valid && bus.in_ready;
  assign mul_start = accept && (bus.op == OP_MUL) && MUL_EN;

  always_comb begin
    simple   = alu_simple(bus.op, MAX_W'(bus.a), MAX_W'(bus.b), WIDTH);
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    load     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL;
        end else if (accept) begin
          result_d = simple.result[WIDTH-1:0];
          carry_d  = simple.carry;
          ovf_d    = simple.ovf;
          load     = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
          ovf_d    = 1'b0;
          load     = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // zero/neg only follow a freshly loaded result, so they stay 0 after reset.
    if (load) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[WIDTH-1];
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign busy          = (state_q == ST_MUL) || (state_q == ST_DONE);
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8, MUL_EN=1) with hand-computed expectations.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int want);
    n_total++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Present one request for exactly one edge; returns #1 into the cycle after accept.
  task automatic issue(input string tag, input op_e o, input logic [7:0] x, input logic [7:0] y);
    chk1({tag, ".in_ready_pre"}, bus.in_ready, 1'b1);
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk1({tag, ".out_valid_after"}, bus.out_valid, 1'b0);
    chk1({tag, ".in_ready_after"}, bus.in_ready, 1'b1);
  endtask

  task automatic run_simple(input string tag, input op_e o, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] r, input logic c, input logic z, input logic n,
                            input logic v);
    issue(tag, o, x, y);
    chk1({tag, ".out_valid"}, bus.out_valid, 1'b1);
    chk8({tag, ".result"}, bus.result, r);
    chk1({tag, ".carry"}, bus.carry, c);
    chk1({tag, ".zero"}, bus.zero, z);
    chk1({tag, ".neg"}, bus.neg, n);
    chk1({tag, ".ovf"}, bus.ovf, v);
    drain(tag);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] r, input logic c, input logic z, input logic n);
    int cyc;
    issue(tag, OP_MUL, x, y);
    chk1({tag, ".busy"}, busy, 1'b1);
    chk1({tag, ".in_ready_busy"}, bus.in_ready, 1'b0);
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chkn({tag, ".latency"}, cyc, W + 1);
    chk8({tag, ".result"}, bus.result, r);
    chk1({tag, ".carry"}, bus.carry, c);
    chk1({tag, ".zero"}, bus.zero, z);
    chk1({tag, ".neg"}, bus.neg, n);
    chk1({tag, ".ovf"}, bus.ovf, 1'b0);
    drain(tag);
  endtask

  initial begin
    logic seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_AND;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    tick();
    tick();

    // Reset state
    chk1("rst.in_ready", bus.in_ready, 1'b0);
    chk1("rst.out_valid", bus.out_valid, 1'b0);
    chk8("rst.result", bus.result, 8'h00);
    chk1("rst.carry", bus.carry, 1'b0);
    chk1("rst.zero", bus.zero, 1'b0);
    chk1("rst.neg", bus.neg, 1'b0);
    chk1("rst.ovf", bus.ovf, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst.in_ready_release", bus.in_ready, 1'b1);

    // Arithmetic edge cases
    run_simple("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_simple("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    run_simple("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_simple("sub_01_02", OP_SUB, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Logic ops
    run_simple("or_0f_30", OP_OR, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
    run_simple("xor_aa_aa", OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Shifts, including the zero-amount boundary
    run_simple("shl_81_1", OP_SHL, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run_simple("shl_81_0", OP_SHL, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    run_simple("shr_81_7", OP_SHR, 8'h81, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_simple("shr_81_1", OP_SHR, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);

    // Multiplier
    run_mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b1);
    run_mul("mul_10_10", 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0);

    // Output backpressure: result held, new requests ignored
    issue("hold", OP_ADD, 8'h05, 8'h03);
    bus.in_valid = 1'b1;
    bus.op       = OP_SUB;
    bus.a        = 8'h55;
    bus.b        = 8'h01;
    for (int i = 0; i < 5; i++) begin
      chk8("hold.result", bus.result, 8'h08);
      chk1("hold.in_ready", bus.in_ready, 1'b0);
      chk1("hold.out_valid", bus.out_valid, 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    drain("hold");
    chk8("hold.result_after", bus.result, 8'h08);

    // Reset in the middle of a multiply
    issue("abort", OP_MUL, 8'h0F, 8'h11);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk1("abort.in_ready_in_rst", bus.in_ready, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk1("abort.in_ready", bus.in_ready, 1'b1);
    chk1("abort.busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk1("abort.no_out_valid", seen, 1'b0);
    run_simple("and_f0_3c", OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
